// File: rtl/morse_seq_detect.sv
// morse_seq_detect: classifies a sampled serial line into Morse dots, dashes and gaps.
// It decodes each letter into a code/length pair. A programmable A-B-A letter sequence
// is detected, which is SOS when A=S and B=O.
// Optional build macro MORSE_STATE_DBG_EN exposes the line FSM state as two extra outputs.

module morse_seq_detect #(
    parameter int unsigned DOT_MAX  = 1,
    parameter int unsigned DASH_MAX = 4,
    parameter int unsigned GAP_MIN  = 3,
    parameter int unsigned WORD_GAP = 7,
    parameter int unsigned MAX_SYM  = 5,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in,
    input  logic [MAX_SYM-1:0]             pat_a_code,
    input  logic [$clog2(MAX_SYM+1)-1:0]   pat_a_len,
    input  logic [MAX_SYM-1:0]             pat_b_code,
    input  logic [$clog2(MAX_SYM+1)-1:0]   pat_b_len,
    output logic                           letter_valid,
    output logic [MAX_SYM-1:0]             letter_code,
    output logic [$clog2(MAX_SYM+1)-1:0]   letter_len,
    output logic                           match_a,
    output logic                           seq_hit,
    output logic                           err
`ifdef MORSE_STATE_DBG_EN
    ,
    output logic [1:0]                     current_state,
    output logic [1:0]                     next_state
`endif
);

    localparam int unsigned LEN_W = $clog2(MAX_SYM + 1);

    localparam logic [CNT_W-1:0] DotMax  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DashMax = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GapMin  = CNT_W'(GAP_MIN);
    localparam logic [CNT_W-1:0] WordGap = CNT_W'(WORD_GAP);
    localparam logic [LEN_W-1:0] MaxSym  = LEN_W'(MAX_SYM);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMark  = 2'd1,
        StSpace = 2'd2,
        StErr   = 2'd3
    } line_state_e;

    typedef enum logic [1:0] {
        TrkS0    = 2'd0,
        TrkGotA  = 2'd1,
        TrkGotAb = 2'd2
    } trk_state_e;

    line_state_e          state_q, state_d;
    trk_state_e           trk_q, trk_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [MAX_SYM-1:0]   code_q, code_d;
    logic [LEN_W-1:0]     len_q, len_d;

    logic                 emit;
    logic                 trk_clr;
    logic                 word_clr;
    logic                 is_a, is_b;
    logic                 hit_d;

    logic                 letter_valid_q, match_a_q, seq_hit_q, err_q;
    logic [MAX_SYM-1:0]   letter_code_q;
    logic [LEN_W-1:0]     letter_len_q;

    // A zero-length pattern is a disabled pattern and never matches.
    function automatic logic letter_eq(input logic [MAX_SYM-1:0] code,
                                       input logic [LEN_W-1:0]   len,
                                       input logic [MAX_SYM-1:0] pcode,
                                       input logic [LEN_W-1:0]   plen);
        return (plen != '0) && (len == plen) && (code == pcode);
    endfunction

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign is_a    = letter_eq(code_q, len_q, pat_a_code, pat_a_len);
    assign is_b    = letter_eq(code_q, len_q, pat_b_code, pat_b_len);

    // Line FSM next state: run counting, symbol buffering and letter emit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        len_d   = len_q;
        emit    = 1'b0;
        trk_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in) begin
                    state_d = StMark;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StMark: begin
                if (in) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc > DashMax) begin
                        state_d = StErr;
                        cnt_d   = '0;
                        code_d  = '0;
                        len_d   = '0;
                        trk_clr = 1'b1;
                    end
                end else if (len_q == MaxSym) begin
                    // Buffer full: this mark would be one symbol too many.
                    state_d = StErr;
                    cnt_d   = '0;
                    code_d  = '0;
                    len_d   = '0;
                    trk_clr = 1'b1;
                end else begin
                    code_d  = code_q | (MAX_SYM'(cnt_q > DotMax) << len_q);
                    len_d   = len_q + LEN_W'(1);
                    state_d = StSpace;
                    cnt_d   = CNT_W'(1);
                end
            end
            StSpace: begin
                if (in) begin
                    state_d = StMark;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GapMin) begin
                        emit    = 1'b1;
                        code_d  = '0;
                        len_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            StErr: begin
                // Counts only zeros sampled while in error; any mark restarts the count.
                if (in) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GapMin) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Word gap: the zero count reaches WORD_GAP while idle (or on the emit edge itself).
    assign word_clr = !in && (cnt_inc == WordGap) && ((state_q == StIdle) || emit);

    // Sequence tracker next state; the letter is applied before any word-gap clear.
    always_comb begin
        trk_d = trk_q;
        hit_d = 1'b0;
        if (emit) begin
            unique case (trk_q)
                TrkS0:    trk_d = is_a ? TrkGotA : TrkS0;
                TrkGotA: begin
                    if (is_b)      trk_d = TrkGotAb;
                    else if (is_a) trk_d = TrkGotA;
                    else           trk_d = TrkS0;
                end
                TrkGotAb: begin
                    hit_d = is_a;
                    trk_d = is_a ? TrkGotA : TrkS0;
                end
                default:  trk_d = TrkS0;
            endcase
        end
        if (word_clr || trk_clr) begin
            trk_d = TrkS0;
        end
    end

    // State, counter and symbol buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            trk_q   <= TrkS0;
            cnt_q   <= '0;
            code_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            trk_q   <= trk_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            len_q   <= len_d;
        end
    end

    // Registered outputs; letter code/length hold between emits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            letter_valid_q <= 1'b0;
            letter_code_q  <= '0;
            letter_len_q   <= '0;
            match_a_q      <= 1'b0;
            seq_hit_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            letter_valid_q <= emit;
            match_a_q      <= emit && is_a;
            seq_hit_q      <= hit_d;
            err_q          <= (state_d == StErr);
            if (emit) begin
                letter_code_q <= code_q;
                letter_len_q  <= len_q;
            end
        end
    end

    assign letter_valid = letter_valid_q;
    assign letter_code  = letter_code_q;
    assign letter_len   = letter_len_q;
    assign match_a      = match_a_q;
    assign seq_hit      = seq_hit_q;
    assign err          = err_q;

`ifdef MORSE_STATE_DBG_EN
    assign current_state = state_q;
    assign next_state    = state_d;
`endif

endmodule

// File: doc/morse_seq_detect.md
# morse_seq_detect

Parametrised successor to the SOS detector. Classifies a sampled serial line `in` into Morse marks (dot/dash) and gaps by run length. Decodes each letter into a code/length pair and detects a programmable three-letter sequence A-B-A (SOS when A=S, B=O). Sits behind the input synchroniser and feeds the alarm/status logic.

## Interface

Parameters:
- `DOT_MAX`, 1: longest mark (cycles) classed as dot.
- `DASH_MAX`, 4: longest legal mark; longer is an error.
- `GAP_MIN`, 3: consecutive 0 samples that end a letter.
- `WORD_GAP`, 7: consecutive 0 samples that clear the sequence tracker.
- `MAX_SYM`, 5: maximum symbols per letter.
- `CNT_W`, 4: run counter width; must hold `WORD_GAP`.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in`  in  1  serial line, sampled every `clk`.
- `pat_a_code`  in  MAX_SYM  letter A symbols; bit0 = first; 1 = dash.
- `pat_a_len`  in  $clog2(MAX_SYM+1)  letter A symbol count.
- `pat_b_code`  in  MAX_SYM  letter B symbols.
- `pat_b_len`  in  $clog2(MAX_SYM+1)  letter B symbol count.
- `letter_valid`  out  1  one-cycle strobe: decoded letter available.
- `letter_code`  out  MAX_SYM  decoded symbols; unused upper bits 0.
- `letter_len`  out  $clog2(MAX_SYM+1)  decoded symbol count.
- `match_a`  out  1  with `letter_valid`: letter equals A.
- `seq_hit`  out  1  one-cycle strobe: A-B-A completed.
- `err`  out  1  high while in ERR state.

## Operation

- Line FSM: IDLE, MARK, SPACE, ERR. Run counter `cnt` saturates at 2^CNT_W-1.
- IDLE:
  - `in`=0: stay; `cnt`++.
  - `in`=1: go to MARK, `cnt`=1.
- MARK:
  - `in`=1: `cnt`++. If the new count exceeds `DASH_MAX`, go to ERR.
  - `in`=0: append symbol (dot if `cnt`≤`DOT_MAX`, else dash). If `MAX_SYM` symbols are already buffered, go to ERR instead. Otherwise go to SPACE, `cnt`=1.
- SPACE:
  - `in`=1: intra-letter gap; go to MARK, `cnt`=1.
  - `in`=0: `cnt`++. When the count reaches `GAP_MIN`: emit letter, clear buffer, go to IDLE with `cnt` continuing.
- ERR:
  - Buffer discarded; no letter is emitted.
  - Exit to IDLE after `GAP_MIN` consecutive 0s; any 1 restarts that count.
  - Entering ERR resets the tracker.
- Letter match: `len` equal and `code` equal. A pattern length of 0 never matches. Patterns are sampled on the emit edge only.
- Sequence tracker: states S0, GOT_A, GOT_AB. Transitions on each emitted letter:
  - S0: A goes to GOT_A.
  - GOT_A: B goes to GOT_AB; A stays in GOT_A.
  - GOT_AB: A asserts `seq_hit` and goes to GOT_A (overlap: trailing A starts the next sequence).
  - Any other letter: GOT_A if the letter is A, else S0.
  - `cnt` reaching `WORD_GAP` in IDLE: S0.

## Timing

- All outputs registered.
- Reset values:
  - `letter_valid`, `match_a`, `seq_hit`, `err`: 0.
  - `letter_code`, `letter_len`: 0.
  - FSM: IDLE, tracker S0, `cnt` 0, buffer empty.
- `letter_valid`, `match_a` and `seq_hit` assert for exactly one cycle after the edge that samples the `GAP_MIN`-th trailing 0.
- `letter_code`/`letter_len` hold until the next emit.
- `err` rises on the edge after the violating sample. It falls on the edge after the `GAP_MIN`-th 0.
- Dot/dash boundary: a mark of exactly `DOT_MAX` cycles is a dot; `DOT_MAX`+1 is a dash. A mark of exactly `DASH_MAX` cycles is legal.
- Reset mid-letter discards all progress; outputs return to reset values asynchronously.
- `in`=1 on the same edge as the `WORD_GAP` count is impossible (the count requires `in`=0). `GAP_MIN`==`WORD_GAP` is legal: the letter emit applies first, then the clear.

## Configuration

- `MORSE_STATE_DBG_EN`:
  - Defined: adds output ports `current_state`[1:0] and `next_state`[1:0] (IDLE=0, MARK=1, SPACE=2, ERR=3) for bench observation.
  - Undefined: ports absent; functional behaviour identical.

## Test plan

All scenarios use default parameters, A=S (code 3'b000, len 3), B=O (code 3'b111, len 3).

- **Reset:** reset asserted with `in` toggling -> all outputs 0 throughout. First `letter_valid` only after release.
- **Single S:** `in`=1,0,1,0,1,0,0,0 -> `letter_valid`=1, `letter_len`=3, `letter_code`=0, `match_a`=1, one cycle after the 8th sample.
- **Dash boundary:** mark of 4 then 3 zeros -> letter len 1, code 1. Mark of 5 -> `err`=1 the cycle after the 5th one, falls after 3 zeros, no letter emitted.
- **SOS stream:** S, 3-cycle gap, O (each dash 3 ones, 1-zero intra gaps), gap, S -> `seq_hit`=1 for one cycle coincident with the final S `letter_valid`. Appending O,S -> a second `seq_hit` (overlap).
- **Word gap:** S, O, then 7+ zeros, then S -> no `seq_hit`.
- **Symbol overflow:** six dots without a 3-zero gap -> `err` on the sixth mark's falling edge; the next letter decodes cleanly after recovery.
